mac_vec_feeder: RTL and testbench
=================================

Name: mac_vec_feeder

Overview:
Upstream sequencer for the mac accumulator. It buffers operand pairs in a small FIFO and, on a length command, issues exactly that many a/b/en beats to the mac. It then returns the dot product of that vector. The result is the mac output delta since command accept, so no accumulator clear is needed.

Parameters:
WIDTH, 16, accumulator width; operands are WIDTH/2 bits, unsigned
DEPTH, 4, operand FIFO entries (power of two, >=2)
LEN_W, 8, command length width

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
op_valid  in  1  operand pair valid
op_ready  out  1  FIFO can accept
op_a  in  WIDTH/2  operand a
op_b  in  WIDTH/2  operand b
cmd_valid  in  1  command valid
cmd_ready  out  1  command accepted when high with cmd_valid
cmd_len  in  LEN_W  number of products to accumulate (0 allowed)
mac_a  out  WIDTH/2  to mac a
mac_b  out  WIDTH/2  to mac b
mac_en  out  1  to mac en
mac_out  in  WIDTH  from mac out
res_valid  out  1  result valid
res_ready  in  1  result consumed
res_data  out  WIDTH  dot product, modulo 2^WIDTH
res_ovf  out  1  overflow flag (see Optional Feature)
busy  out  1  state != IDLE

Behaviour:
- Clocking and reset: one clock, clk. Reset is synchronous and active-high, named reset.
- On reset: state IDLE, FIFO empty, res_valid=0, res_data=0, res_ovf=0, mac_en=0, mac_a=mac_b=0, remaining count=0, base=0.
- Reset mid-operation aborts everything in flight. The mac accumulator is not touched by this block.
- FIFO:
  - push = op_valid & op_ready; op_ready = !full in every state.
  - No push while full, even if a pop occurs in the same cycle.
  - Pushing into an empty FIFO is visible next cycle (no bypass).
- mac_a/mac_b are combinational from the FIFO head when mac_en=1, otherwise 0. mac_en is combinational: state==RUN & !empty.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid, capture base <= mac_out and remaining <= cmd_len.
  - If cmd_len==0, go to DRAIN; otherwise go to RUN.
- RUN:
  - Each cycle with the FIFO non-empty: pop one entry, assert mac_en, remaining--.
  - The pop with remaining==1 goes to DRAIN.
  - FIFO empty stalls with no timeout; busy stays 1.
- DRAIN: one cycle, so the mac registers the last product. Then res_data <= mac_out - base (mod 2^WIDTH) and the state goes to RESP.
- RESP:
  - res_valid=1; res_data and res_ovf hold stable until res_ready.
  - On res_ready, res_valid drops next cycle and the state returns to IDLE.
  - A new command is accepted no earlier than the cycle after the return to IDLE.
- cmd_ready=0 in RUN, DRAIN and RESP.
- Operands pushed during RUN/RESP stay queued for the next command.
- Latency: last mac_en in cycle t gives res_valid in cycle t+2. cmd_len==0 accepted in cycle t gives res_valid in cycle t+2.
- The mac must be driven only by this block while busy, and mac_out must be quiescent in IDLE.

Optional Feature:
MAC_FEEDER_OVF_EN
- Defined:
  - A shadow sum of WIDTH+1 bits is cleared at command accept and adds mac_a*mac_b on every mac_en.
  - A sticky carry bit goes to res_ovf in the DRAIN->RESP transition.
  - res_ovf=1 when the true unsigned dot product is >= 2^WIDTH.
- Undefined: the shadow logic is absent and res_ovf is tied 0.

Test Plan:
1. Reset; mac_out model starts 0; push (2,3),(4,5),(6,7); cmd_len=3 -> mac_en high 3 consecutive cycles with those operands; res_valid 2 cycles after the last en; res_data=68 (0x0044).
2. mac_out=0x1000 at accept; cmd_len=2 with (10,10),(1,1) -> res_data=101; no dependence on base.
3. cmd_len=0 -> mac_en never high; res_valid 2 cycles after accept; res_data=0; res_ovf=0.
4. cmd_len=4; operands pushed every 3rd cycle -> exactly 4 mac_en beats, one per arriving operand; busy=1 and cmd_ready=0 throughout.
5. Backpressure and full FIFO (DEPTH=4):
   - 4 pushes in IDLE -> op_ready=0, 5th push held.
   - res_ready low for 5 cycles in RESP -> res_valid/res_data stable; cmd_ready=0.
   - Reset asserted mid-RUN after 1 of 3 beats -> next cycle mac_en=0, op_ready=1, res_valid=0, busy=0.
6. With MAC_FEEDER_OVF_EN: base 0; (255,255) twice -> res_data=64514, res_ovf=1. Without the macro -> res_ovf=0, same res_data.

Source files
------------

// File: rtl/mac_vec_feeder.sv
// -----------------------------------------------------------------------------
// mac_vec_feeder
//
// Upstream sequencer for an external multiply-accumulate unit. Operand pairs
// are buffered in a small FIFO. A length command then streams exactly that
// many a/b/en beats into the mac. The block then reports the dot product of
// that vector. The result is taken as the change in mac_out since the command
// was accepted, so the accumulator never needs clearing.
//
// Optional build macro: MAC_FEEDER_OVF_EN
//   defined   -> a WIDTH+1 bit shadow sum tracks the true dot product and
//                res_ovf flags results that do not fit in WIDTH bits
//   undefined -> shadow logic absent, res_ovf tied low
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   op_valid/op_ready     operand pair push handshake (op_a, op_b)
//   cmd_valid/cmd_ready   command handshake, cmd_len = products to accumulate
//   mac_a/mac_b/mac_en    drive to the mac
//   mac_out               accumulator value returned by the mac
//   res_valid/res_ready   result handshake (res_data, res_ovf)
//   busy                  high whenever a command is in progress
// -----------------------------------------------------------------------------
module mac_vec_feeder #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4,
  parameter int LEN_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               op_valid,
  output logic               op_ready,
  input  logic [WIDTH/2-1:0] op_a,
  input  logic [WIDTH/2-1:0] op_b,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [LEN_W-1:0]   cmd_len,
  output logic [WIDTH/2-1:0] mac_a,
  output logic [WIDTH/2-1:0] mac_b,
  output logic               mac_en,
  input  logic [WIDTH-1:0]   mac_out,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [WIDTH-1:0]   res_data,
  output logic               res_ovf,
  output logic               busy
);

  localparam int HW = WIDTH / 2;
  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    RESP
  } state_e;

  typedef struct packed {
    logic [HW-1:0] a;
    logic [HW-1:0] b;
  } op_t;

  // ---------------------------------------------------------------------------
  // Operand FIFO
  // Pointers carry one extra wrap bit so full and empty are distinguishable
  // without a separate occupancy counter.
  // ---------------------------------------------------------------------------
  op_t           mem_q [DEPTH];
  op_t           mem_d [DEPTH];
  logic [AW:0]   wr_ptr_q, wr_ptr_d;
  logic [AW:0]   rd_ptr_q, rd_ptr_d;
  logic          fifo_empty;
  logic          fifo_full;
  logic          push;
  logic          pop;
  op_t           head;

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  // A simultaneous pop does not free a slot for a push in the same cycle.
  assign op_ready = !fifo_full;
  assign push     = op_valid && op_ready;
  assign head     = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    mem_d = mem_q;
    if (push) begin
      mem_d[wr_ptr_q[AW-1:0]] = '{a: op_a, b: op_b};
    end
    wr_ptr_d = wr_ptr_q + (AW+1)'(push);
    rd_ptr_d = rd_ptr_q + (AW+1)'(pop);
  end

  // NOTE: storage is deliberately left out of reset; the pointers alone define
  // which entries are valid, and a reset-free array maps onto plain RAM/regs.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  // ---------------------------------------------------------------------------
  // Sequencer
  // ---------------------------------------------------------------------------
  state_e            state_q, state_d;
  logic [LEN_W-1:0]  remaining_q, remaining_d;
  logic [WIDTH-1:0]  base_q, base_d;
  logic [WIDTH-1:0]  res_data_q, res_data_d;
  logic              cmd_accept;

  // A beat is issued on every RUN cycle that has an operand available.
  assign mac_en     = (state_q == RUN) && !fifo_empty;
  assign pop        = mac_en;
  assign mac_a      = mac_en ? head.a : '0;
  assign mac_b      = mac_en ? head.b : '0;
  assign cmd_accept = (state_q == IDLE) && cmd_valid;

  assign res_valid  = (state_q == RESP);
  assign busy       = (state_q != IDLE);
  assign res_data   = res_data_q;

  // NOTE: every signal written here gets a default first, so no path through
  // the case statement can leave a value unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    base_d      = base_q;
    res_data_d  = res_data_q;
    cmd_ready   = 1'b0;

    case (state_q)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          // Snapshot the accumulator so the result is a delta, not an absolute.
          base_d      = mac_out;
          remaining_d = cmd_len;
          state_d     = (cmd_len == '0) ? DRAIN : RUN;
        end
      end
      RUN: begin
        if (!fifo_empty) begin
          remaining_d = remaining_q - 1'b1;
          if (remaining_q == LEN_W'(1)) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        // The mac has registered the final product by now.
        res_data_d = mac_out - base_q;
        state_d    = RESP;
      end
      RESP: begin
        if (res_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours regardless of evaluation order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      remaining_q <= '0;
      base_q      <= '0;
      res_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      remaining_q <= remaining_d;
      base_q      <= base_d;
      res_data_q  <= res_data_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Overflow detection
  // ---------------------------------------------------------------------------
`ifdef MAC_FEEDER_OVF_EN
  logic [WIDTH:0]   shadow_q, shadow_d;
  logic [WIDTH:0]   shadow_sum;
  logic [WIDTH-1:0] prod;
  logic             res_ovf_q, res_ovf_d;

  // Two WIDTH/2-bit operands always fit in a WIDTH-bit product.
  assign prod = WIDTH'(mac_a) * WIDTH'(mac_b);

  always_comb begin
    shadow_d   = shadow_q;
    res_ovf_d  = res_ovf_q;
    shadow_sum = {1'b0, shadow_q[WIDTH-1:0]} + {1'b0, prod};

    if (cmd_accept) begin
      shadow_d = '0;
    end else if (mac_en) begin
      // Top bit is sticky: once any partial sum carries out, the result overflowed.
      shadow_d = {shadow_q[WIDTH] | shadow_sum[WIDTH], shadow_sum[WIDTH-1:0]};
    end

    if (state_q == DRAIN) begin
      res_ovf_d = shadow_q[WIDTH];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      shadow_q  <= '0;
      res_ovf_q <= 1'b0;
    end else begin
      shadow_q  <= shadow_d;
      res_ovf_q <= res_ovf_d;
    end
  end

  assign res_ovf = res_ovf_q;
`else
  assign res_ovf = 1'b0;
`endif

endmodule

// File: tb/tb_mac_vec_feeder.sv
// -----------------------------------------------------------------------------
// tb_mac_vec_feeder
//
// Drives mac_vec_feeder against a simple accumulator model of the mac. Expected
// beats and results come from a queue of accepted operand pairs and plain
// arithmetic over them. Directed scenarios come first, then randomized
// commands.
// -----------------------------------------------------------------------------
module tb_mac_vec_feeder;

  localparam int WIDTH = 16;
  localparam int DEPTH = 4;
  localparam int LEN_W = 8;
  localparam int HW    = WIDTH / 2;

  logic             clk = 1'b0;
  logic             reset;
  logic             op_valid, op_ready;
  logic [HW-1:0]    op_a, op_b;
  logic             cmd_valid, cmd_ready;
  logic [LEN_W-1:0] cmd_len;
  logic [HW-1:0]    mac_a, mac_b;
  logic             mac_en;
  logic [WIDTH-1:0] mac_out;
  logic             res_valid, res_ready;
  logic [WIDTH-1:0] res_data;
  logic             res_ovf, busy;

  always #5 clk = ~clk;

  mac_vec_feeder #(.WIDTH(WIDTH), .DEPTH(DEPTH), .LEN_W(LEN_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .op_valid  (op_valid),
    .op_ready  (op_ready),
    .op_a      (op_a),
    .op_b      (op_b),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_len   (cmd_len),
    .mac_a     (mac_a),
    .mac_b     (mac_b),
    .mac_en    (mac_en),
    .mac_out   (mac_out),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_ovf   (res_ovf),
    .busy      (busy)
  );

  // External mac: accumulator with a preload port for setting arbitrary bases.
  logic [WIDTH-1:0] acc;
  logic             acc_load;
  logic [WIDTH-1:0] acc_load_val;

  always @(posedge clk) begin
    if (acc_load)    acc <= acc_load_val;
    else if (mac_en) acc <= acc + WIDTH'(mac_a) * WIDTH'(mac_b);
  end
  assign mac_out = acc;

  // Reference state.
  typedef struct {
    int unsigned a;
    int unsigned b;
  } pair_t;

  pair_t             model_q[$];
  longint unsigned   exp_sum;
  int                beats;
  int                cyc_n;
  int                first_en_cyc;
  int                last_en_cyc;
  bit                last_push;
  int                errors = 0;
  int                checks = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc_n);
    end
  endtask

  // One clock: evaluate handshakes for the inputs set at this negedge, then
  // advance to the next negedge.
  task automatic tick();
    pair_t h;
    #1;
    if (mac_en) begin
      if (model_q.size() == 0) begin
        check("beat_without_operand", 1, 0);
      end else begin
        h = model_q.pop_front();
        check("mac_a", 64'(mac_a), 64'(h.a));
        check("mac_b", 64'(mac_b), 64'(h.b));
        exp_sum += longint'(h.a) * longint'(h.b);
        if (beats == 0) first_en_cyc = cyc_n;
        beats++;
        last_en_cyc = cyc_n;
      end
    end else begin
      check("mac_ab_zero_when_idle", {mac_a, mac_b}, 0);
    end
    last_push = op_valid && op_ready;
    if (last_push) model_q.push_back('{int'(op_a), int'(op_b)});
    @(negedge clk);
    cyc_n++;
  endtask

  function automatic logic [HW-1:0] rand_op();
    if ($urandom_range(0, 1) == 1) return HW'($urandom_range(240, 255));
    return HW'($urandom_range(0, 255));
  endfunction

  task automatic set_acc(input logic [WIDTH-1:0] v);
    acc_load     = 1'b1;
    acc_load_val = v;
    tick();
    acc_load     = 1'b0;
  endtask

  // Push one pair while IDLE; the mac must stay untouched meanwhile.
  task automatic push_one(input logic [HW-1:0] a, input logic [HW-1:0] b);
    int tries = 0;
    op_valid = 1'b1;
    op_a     = a;
    op_b     = b;
    do begin
      check("idle_no_mac_en", 64'(mac_en), 0);
      tick();
      tries++;
    end while (!last_push && tries < 10);
    if (!last_push) check("push_timeout", 1, 0);
    op_valid = 1'b0;
  endtask

  // Issue a command, optionally feed operands during the run, then check the
  // beat count, latency, result and the response handshake.
  task automatic do_command(input int len, input int gap, input int n_push,
                            input int hold, input int exp_const, input string tag);
    int accept_cyc, pushed, since, waited, exp_lat_ref;
    logic [WIDTH-1:0] exp_data;
    logic             exp_ovf;

    check({tag, "_cmd_ready"}, 64'(cmd_ready), 1);
    cmd_valid  = 1'b1;
    cmd_len    = LEN_W'(len);
    beats      = 0;
    exp_sum    = 0;
    accept_cyc = cyc_n;
    tick();
    cmd_valid  = 1'b0;

    pushed = 0;
    since  = 0;
    waited = 0;
    while (!res_valid && waited < 300) begin
      check({tag, "_busy"}, 64'(busy), 1);
      check({tag, "_cmd_ready_busy"}, 64'(cmd_ready), 0);
      op_valid = (pushed < n_push) && (since >= gap);
      op_a     = rand_op();
      op_b     = rand_op();
      tick();
      if (last_push) begin
        pushed++;
        since = 0;
      end else begin
        since++;
      end
      op_valid = 1'b0;
      waited++;
    end
    if (!res_valid) begin
      check({tag, "_res_timeout"}, 1, 0);
      return;
    end

    exp_data = exp_sum[WIDTH-1:0];
`ifdef MAC_FEEDER_OVF_EN
    exp_ovf  = (exp_sum >= (64'd1 << WIDTH));
`else
    exp_ovf  = 1'b0;
`endif
    exp_lat_ref = (len == 0) ? accept_cyc : last_en_cyc;
    check({tag, "_beats"}, 64'(beats), 64'(len));
    check({tag, "_latency"}, 64'(cyc_n), 64'(exp_lat_ref + 2));
    check({tag, "_res_data"}, 64'(res_data), 64'(exp_data));
    check({tag, "_res_ovf"}, 64'(res_ovf), 64'(exp_ovf));
    if (exp_const >= 0) check({tag, "_res_const"}, 64'(res_data), 64'(exp_const));

    res_ready = 1'b0;
    for (int i = 0; i < hold; i++) begin
      tick();
      check({tag, "_hold_valid"}, 64'(res_valid), 1);
      check({tag, "_hold_data"}, 64'(res_data), 64'(exp_data));
      check({tag, "_hold_ovf"}, 64'(res_ovf), 64'(exp_ovf));
      check({tag, "_hold_cmd_ready"}, 64'(cmd_ready), 0);
    end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    check({tag, "_valid_drop"}, 64'(res_valid), 0);
    check({tag, "_idle_busy"}, 64'(busy), 0);
    check({tag, "_idle_cmd_ready"}, 64'(cmd_ready), 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int pre, n_push, len, avail;

    reset        = 1'b1;
    op_valid     = 1'b0;
    op_a         = '0;
    op_b         = '0;
    cmd_valid    = 1'b0;
    cmd_len      = '0;
    res_ready    = 1'b0;
    acc_load     = 1'b1;
    acc_load_val = '0;
    cyc_n        = 0;
    beats        = 0;
    exp_sum      = 0;
    repeat (3) @(negedge clk);
    reset    = 1'b0;
    acc_load = 1'b0;
    #1;

    // Reset state.
    check("rst_op_ready", 64'(op_ready), 1);
    check("rst_cmd_ready", 64'(cmd_ready), 1);
    check("rst_busy", 64'(busy), 0);
    check("rst_res_valid", 64'(res_valid), 0);
    check("rst_res_data", 64'(res_data), 0);
    check("rst_res_ovf", 64'(res_ovf), 0);
    check("rst_mac_en", 64'(mac_en), 0);
    check("rst_mac_ab", {mac_a, mac_b}, 0);
    @(negedge clk);

    // 1: basic three-term dot product, beats back to back.
    push_one(8'd2, 8'd3);
    push_one(8'd4, 8'd5);
    push_one(8'd6, 8'd7);
    do_command(3, 0, 0, 0, 68, "t1");
    check("t1_beats_consecutive", 64'(last_en_cyc - first_en_cyc), 2);

    // 2: non-zero accumulator base.
    set_acc(16'h1000);
    push_one(8'd10, 8'd10);
    push_one(8'd1, 8'd1);
    do_command(2, 0, 0, 1, 101, "t2");

    // 3: zero-length command.
    do_command(0, 0, 0, 0, 0, "t3");
    check("t3_no_beats", 64'(beats), 0);

    // 4: operands trickle in every third cycle while running.
    do_command(4, 2, 4, 0, -1, "t4");

    // 5a: fill the FIFO while idle; a fifth push must be held off.
    for (int i = 0; i < DEPTH; i++) push_one(rand_op(), rand_op());
    check("t5_full_op_ready", 64'(op_ready), 0);
    op_valid = 1'b1;
    op_a     = rand_op();
    op_b     = rand_op();
    repeat (2) begin
      tick();
      check("t5_fifth_push_held", 64'(last_push), 0);
    end
    op_valid = 1'b0;
    // 5b: result held under res_ready backpressure.
    do_command(4, 0, 0, 5, -1, "t5");

    // 5c: reset one beat into a three-beat run.
    for (int i = 0; i < 3; i++) push_one(rand_op(), rand_op());
    cmd_valid = 1'b1;
    cmd_len   = LEN_W'(3);
    beats     = 0;
    tick();
    cmd_valid = 1'b0;
    tick();
    check("t5_one_beat_before_reset", 64'(beats), 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    model_q.delete();
    check("t5_rst_mac_en", 64'(mac_en), 0);
    check("t5_rst_op_ready", 64'(op_ready), 1);
    check("t5_rst_res_valid", 64'(res_valid), 0);
    check("t5_rst_busy", 64'(busy), 0);
    tick();
    check("t5_rst_fifo_empty_no_en", 64'(mac_en), 0);

    // 6: two maximal products exceed the accumulator width.
    set_acc('0);
    push_one(8'd255, 8'd255);
    push_one(8'd255, 8'd255);
    do_command(2, 0, 0, 0, 64514, "t6");
`ifdef MAC_FEEDER_OVF_EN
    check("t6_ovf_const", 64'(res_ovf), 1);
`else
    check("t6_ovf_const", 64'(res_ovf), 0);
`endif

    // Randomized commands, leaving leftovers queued between commands.
    for (int it = 0; it < 25; it++) begin
      if ($urandom_range(0, 3) == 0) set_acc(WIDTH'($urandom));
      pre = $urandom_range(0, DEPTH - model_q.size());
      for (int i = 0; i < pre; i++) push_one(rand_op(), rand_op());
      n_push = $urandom_range(0, 4);
      avail  = model_q.size() + n_push;
      len    = $urandom_range(0, (avail > 6) ? 6 : avail);
      do_command(len, $urandom_range(0, 3), n_push, $urandom_range(0, 3), -1, "rnd");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
